// File: rtl/adc_pkg.sv
// adc_pkg: shared constants, FSM state encoding, round-robin and lowest-bit pick helpers
package adc_pkg;
  localparam int ADC_NCH = 8;
  localparam int ADC_CHW = 3;
  localparam int ADC_DW = 12;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DELIVER} state_t;
  function automatic logic [ADC_CHW-1:0] rr_pick(input logic [ADC_NCH-1:0] vec, input logic [ADC_CHW-1:0] ptr, input int n);
    logic [ADC_CHW-1:0] r;
    logic f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < ADC_NCH; i++) begin
      int k;
      k = (int'(ptr) + i) % n;
      if (!f && i < n && vec[k[ADC_CHW-1:0]]) begin
        r = k[ADC_CHW-1:0];
        f = 1'b1;
      end
    end
    return r;
  endfunction
  function automatic logic [ADC_CHW-1:0] lsb_idx(input logic [ADC_NCH-1:0] m);
    logic [ADC_CHW-1:0] r;
    r = '0;
    for (int i = ADC_NCH - 1; i >= 0; i--) if (m[i]) r = ADC_CHW'(i);
    return r;
  endfunction
endpackage

// File: rtl/adc_scan_timer.sv
// adc_scan_timer: sweep trigger counter, latched mask, next-channel pointer (oCH), pending and sticky overrun flags
module adc_scan_timer import adc_pkg::*; #(
  parameter int SCAN_PERIOD = 50000
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  input  logic [ADC_NCH-1:0] iMASK,
  input  logic               iADV,
  output logic               oPENDING,
  output logic [ADC_CHW-1:0] oCH,
  output logic               oOVR
);
  localparam int CW = $clog2(SCAN_PERIOD);
  logic [CW-1:0] r_cnt;
  logic [ADC_NCH-1:0] r_mask;
  logic [ADC_CHW-1:0] r_ch;
  logic r_pend, r_ovr, w_fire;
  logic [ADC_NCH-1:0] w_rem;
  assign w_fire = iEN && r_cnt == CW'(SCAN_PERIOD - 1);
  assign w_rem = r_mask & ~(ADC_NCH'(1) << r_ch);
  assign oPENDING = r_pend;
  assign oCH = r_ch;
  assign oOVR = r_ovr;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt <= '0;
      r_mask <= '0;
      r_ch <= '0;
      r_pend <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_cnt <= (!iEN || w_fire) ? '0 : r_cnt + 1'b1;
      if (w_fire && r_pend) r_ovr <= 1'b1;
      if (iADV) begin
        r_mask <= w_rem;
        r_pend <= |w_rem;
        r_ch <= lsb_idx(w_rem);
      end else if (w_fire && !r_pend && |iMASK) begin
        r_mask <= iMASK;
        r_ch <= lsb_idx(iMASK);
        r_pend <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/adc_conv_sched.sv
// adc_conv_sched: round-robin scheduler sharing one serial ADC engine between requesters and a background scanner, with result bank
module adc_conv_sched import adc_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int DW = ADC_DW,
  parameter int SCAN_PERIOD = 50000,
  parameter int TIMEOUT = 64
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [N_REQ-1:0]   iREQ,
  input  logic [3*N_REQ-1:0] iREQ_CH,
  output logic               oVALID,
  output logic [2:0]         oID,
  output logic [DW-1:0]      oDATA,
  output logic               oERR,
  input  logic               iSCAN_EN,
  input  logic [7:0]         iSCAN_MASK,
  output logic               oSCAN_OVR,
  input  logic [2:0]         iRD_CH,
  output logic [DW-1:0]      oRD_DATA,
  output logic               oADC_START,
  output logic [2:0]         oADC_CH,
  input  logic               iADC_DONE,
  input  logic [DW-1:0]      iADC_DATA
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_t r_state, w_next;
  logic [2:0] r_win, r_ch, r_rr, w_pick, w_sel_ch, w_scan_ch;
  logic [DW-1:0] r_data, r_rd;
  logic [DW-1:0] r_bank [ADC_NCH];
  logic [TW-1:0] r_tcnt;
  logic r_err, w_pend, w_adv, w_timeout;
  logic [ADC_NCH-1:0] w_vec;
  assign w_vec = ADC_NCH'({w_pend, iREQ});
  assign w_pick = rr_pick(w_vec, r_rr, N_REQ + 1);
  assign w_adv = r_state == S_DELIVER && r_win == 3'(N_REQ);
  assign w_timeout = r_tcnt == TW'(TIMEOUT - 1);
  assign oID = r_win;
  assign oDATA = r_data;
  assign oERR = r_err;
  assign oADC_CH = r_ch;
  assign oRD_DATA = r_rd;
  always_comb begin
    w_sel_ch = w_scan_ch;
    for (int k = 0; k < N_REQ; k++) if (w_pick == 3'(k)) w_sel_ch = iREQ_CH[3*k +: 3];
  end
  adc_scan_timer #(.SCAN_PERIOD(SCAN_PERIOD)) u_scan (
    .iCLK(iCLK),
    .iRST(iRST),
    .iEN(iSCAN_EN),
    .iMASK(iSCAN_MASK),
    .iADV(w_adv),
    .oPENDING(w_pend),
    .oCH(w_scan_ch),
    .oOVR(oSCAN_OVR)
  );
  always_ff @(posedge iCLK) r_state <= iRST ? S_IDLE : w_next;
  always_comb begin
    oADC_START = r_state == S_START;
    oVALID = r_state == S_DELIVER;
    w_next = r_state == S_IDLE ? (|w_vec ? S_START : S_IDLE) :
             r_state == S_START ? S_WAIT :
             r_state == S_WAIT ? ((iADC_DONE || w_timeout) ? S_DELIVER : S_WAIT) : S_IDLE;
  end
  // The timeout counter runs from the START cycle so an abort lands exactly TIMEOUT cycles after START.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_win <= '0;
      r_ch <= '0;
      r_rr <= '0;
      r_data <= '0;
      r_err <= 1'b0;
      r_tcnt <= '0;
      r_rd <= '0;
      for (int i = 0; i < ADC_NCH; i++) r_bank[i] <= '0;
    end else begin
      r_rd <= r_bank[iRD_CH];
      r_tcnt <= (r_state == S_START || r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
      if (r_state == S_IDLE && |w_vec) begin
        r_win <= w_pick;
        r_ch <= w_sel_ch;
      end
      if (r_state == S_WAIT && iADC_DONE) begin
        r_data <= iADC_DATA;
        r_err <= 1'b0;
      end else if (r_state == S_WAIT && w_timeout) begin
        r_data <= '0;
        r_err <= 1'b1;
      end
      if (w_adv && !r_err) r_bank[r_ch] <= r_data;
      if (r_state == S_DELIVER) r_rr <= r_win == 3'(N_REQ) ? '0 : r_win + 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_conv_sched.sv
// tb_adc_conv_sched: directed and randomized checks of adc_conv_sched against an engine model and round-robin model
module tb_adc_conv_sched;
  localparam int N_REQ = 2;
  localparam int DW = 12;
  localparam int SP = 100;
  localparam int TO = 64;
  localparam int SCAN = N_REQ;
  logic iCLK = 1'b0;
  logic iRST;
  logic [N_REQ-1:0] iREQ;
  logic [3*N_REQ-1:0] iREQ_CH;
  logic oVALID, oERR, iSCAN_EN, oSCAN_OVR, oADC_START, iADC_DONE;
  logic [2:0] oID, iRD_CH, oADC_CH;
  logic [DW-1:0] oDATA, oRD_DATA, iADC_DATA;
  logic [7:0] iSCAN_MASK;
  typedef struct {
    int ch;
    int data;
    int err;
    int t_valid;
  } conv_t;
  conv_t q[$];
  int checks = 0, errors = 0, cyc = 0, rr_ptr = 0;
  int eng_delay = 10, eng_data = -1;
  int last_id, last_ch, last_data, last_err;
  int bank_m [8];

  adc_conv_sched #(.N_REQ(N_REQ), .DW(DW), .SCAN_PERIOD(SP), .TIMEOUT(TO)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iREQ(iREQ),
    .iREQ_CH(iREQ_CH),
    .oVALID(oVALID),
    .oID(oID),
    .oDATA(oDATA),
    .oERR(oERR),
    .iSCAN_EN(iSCAN_EN),
    .iSCAN_MASK(iSCAN_MASK),
    .oSCAN_OVR(oSCAN_OVR),
    .iRD_CH(iRD_CH),
    .oRD_DATA(oRD_DATA),
    .oADC_START(oADC_START),
    .oADC_CH(oADC_CH),
    .iADC_DONE(iADC_DONE),
    .iADC_DATA(iADC_DATA)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input int set, input int ptr);
    for (int i = 0; i <= N_REQ; i++) begin
      int k;
      k = (ptr + i) % (N_REQ + 1);
      if (set[k]) return k;
    end
    return -1;
  endfunction

  always @(negedge iCLK) if (!iRST && (oVALID || oADC_START)) chk("start_valid_excl", {31'b0, oVALID && oADC_START}, 0);

  // Engine model: each START draws a latency and value; latency >= TO means the engine never answers.
  initial begin
    iADC_DONE = 1'b0;
    iADC_DATA = '0;
    forever begin
      @(negedge iCLK);
      if (oADC_START) begin
        conv_t c;
        int d, v;
        d = eng_delay < 0 ? int'($urandom_range(80, 1)) : eng_delay;
        v = eng_data < 0 ? int'($urandom_range(4095, 0)) : eng_data;
        c.ch = int'(oADC_CH);
        c.err = d >= TO ? 1 : 0;
        c.data = c.err != 0 ? 0 : v;
        c.t_valid = cyc + (c.err != 0 ? TO : d + 1);
        q.push_back(c);
        if (c.err == 0) begin
          repeat (d) @(negedge iCLK);
          iADC_DONE = 1'b1;
          iADC_DATA = DW'(v);
          @(negedge iCLK);
          iADC_DONE = 1'b0;
        end
      end
    end
  end

  task automatic deliver(input string tag, input int id, input int ch);
    bit ok;
    conv_t c;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge iCLK);
      ok = oVALID;
    end
    chk({tag, "_valid"}, {31'b0, ok}, 1);
    if (ok) begin
      chk({tag, "_queue"}, {31'b0, q.size() != 0}, 1);
      if (q.size() != 0) begin
        c = q.pop_front();
        if (id >= 0) chk({tag, "_id"}, oID, id);
        if (ch >= 0) chk({tag, "_ch"}, c.ch, ch);
        chk({tag, "_data"}, oDATA, c.data);
        chk({tag, "_err"}, oERR, c.err);
        chk({tag, "_cycle"}, cyc, c.t_valid);
        last_id = int'(oID);
        last_ch = c.ch;
        last_data = c.data;
        last_err = c.err;
        rr_ptr = (last_id + 1) % (N_REQ + 1);
        if (last_id < N_REQ) iREQ[last_id] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1);
  end

  initial begin
    iRST = 1'b1;
    iREQ = '0;
    iREQ_CH = '0;
    iSCAN_EN = 1'b0;
    iSCAN_MASK = '0;
    iRD_CH = '0;
    for (int i = 0; i < 8; i++) bank_m[i] = 0;
    repeat (3) @(negedge iCLK);
    chk("rst_valid", oVALID, 0);
    chk("rst_id", oID, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_err", oERR, 0);
    chk("rst_start", oADC_START, 0);
    chk("rst_ch", oADC_CH, 0);
    chk("rst_ovr", oSCAN_OVR, 0);
    chk("rst_rd", oRD_DATA, 0);
    iRST = 1'b0;
    // single request
    eng_delay = 20;
    eng_data = 'hABC;
    @(negedge iCLK);
    iREQ_CH[2:0] = 3'd5;
    iREQ = 2'b01;
    @(negedge iCLK);
    chk("single_start", oADC_START, 1);
    chk("single_adc_ch", oADC_CH, 5);
    deliver("single", 0, 5);
    @(negedge iCLK);
    chk("single_strobe", oVALID, 0);
    // contention, both held
    eng_delay = 15;
    eng_data = -1;
    iREQ_CH = {3'd6, 3'd2};
    iREQ = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = model_pick(3, rr_ptr);
      deliver("contend", p, p != 0 ? 6 : 2);
      if (i == 3) iREQ = '0;
      @(negedge iCLK);
      if (i < 3) iREQ[p] = 1'b1;
    end
    repeat (3) @(negedge iCLK);
    // timeout and its boundary
    eng_delay = 1000;
    iREQ_CH = {3'd4, 3'd3};
    iREQ = 2'b01;
    deliver("tmo", 0, 3);
    eng_delay = TO - 1;
    iREQ = 2'b10;
    deliver("tmo_edge", 1, 4);
    eng_delay = 10;
    iREQ = 2'b01;
    deliver("after_tmo", 0, 3);
    @(negedge iCLK);
    // randomized rounds
    eng_delay = -1;
    for (int r = 0; r < 12; r++) begin
      int set;
      int chs [N_REQ];
      set = int'($urandom_range(3, 1));
      for (int k = 0; k < N_REQ; k++) begin
        chs[k] = int'($urandom_range(7, 0));
        iREQ_CH[3*k +: 3] = 3'(chs[k]);
      end
      iREQ = N_REQ'(set);
      while (set != 0) begin
        int p;
        p = model_pick(set, rr_ptr);
        deliver("rand", p, chs[p]);
        set &= ~(1 << p);
      end
      @(negedge iCLK);
    end
    // scan sweep over ch0, ch2, ch7
    eng_delay = 5;
    eng_data = -1;
    iSCAN_MASK = 8'b1000_0101;
    iSCAN_EN = 1'b1;
    begin
      int sw [3] = '{0, 2, 7};
      for (int j = 0; j < 3; j++) begin
        int old;
        old = bank_m[sw[j]];
        deliver("scan", SCAN, sw[j]);
        if (last_err == 0) bank_m[sw[j]] = last_data;
        iRD_CH = 3'(sw[j]);
        @(negedge iCLK);
        chk("bank_old", oRD_DATA, old);
        @(negedge iCLK);
        chk("bank_new", oRD_DATA, bank_m[sw[j]]);
      end
    end
    iSCAN_EN = 1'b0;
    begin
      int n;
      n = 0;
      repeat (150) begin
        @(negedge iCLK);
        if (oADC_START) n++;
      end
      chk("scan_done_idle", n, 0);
    end
    chk("scan_no_ovr", oSCAN_OVR, 0);
    // scan conversion that times out leaves the bank entry alone
    eng_delay = 1000;
    iSCAN_MASK = 8'b0000_0100;
    iSCAN_EN = 1'b1;
    deliver("scan_err", SCAN, 2);
    iSCAN_EN = 1'b0;
    iRD_CH = 3'd2;
    repeat (2) @(negedge iCLK);
    chk("bank_keep", oRD_DATA, bank_m[2]);
    // overrun and interleave with requester 1
    eng_delay = 20;
    iSCAN_MASK = 8'hFF;
    iREQ_CH[5:3] = 3'd1;
    iREQ = 2'b10;
    iSCAN_EN = 1'b1;
    begin
      int got;
      got = 1;
      for (int i = 0; i < 10 && got != SCAN; i++) begin
        deliver("ovr_pre", -1, -1);
        got = last_id;
        chk("ovr_pre_src", {31'b0, got == 1 || got == SCAN}, 1);
        if (got == 1) begin
          @(negedge iCLK);
          iREQ[1] = 1'b1;
        end
      end
      chk("ovr_scan_seen", got, SCAN);
      chk("ovr_first_ch", last_ch, 0);
    end
    for (int k = 1; k < 8; k++) begin
      deliver("ovr_req", 1, 1);
      @(negedge iCLK);
      iREQ[1] = 1'b1;
      deliver("ovr_scan", SCAN, k);
    end
    iREQ = '0;
    iSCAN_EN = 1'b0;
    chk("ovr_set", oSCAN_OVR, 1);
    repeat (100) @(negedge iCLK);
    chk("ovr_sticky", oSCAN_OVR, 1);
    iRD_CH = 3'd0;
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    q.delete();
    rr_ptr = 0;
    for (int i = 0; i < 8; i++) bank_m[i] = 0;
    chk("ovr_cleared", oSCAN_OVR, 0);
    chk("bank_reset", oRD_DATA, bank_m[0]);
    // reset in the middle of WAIT
    eng_delay = 30;
    iREQ_CH[2:0] = 3'd7;
    iREQ = 2'b01;
    @(negedge iCLK);
    chk("rw_start", oADC_START, 1);
    repeat (10) @(negedge iCLK);
    iREQ = '0;
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    chk("rw_valid", oVALID, 0);
    chk("rw_start0", oADC_START, 0);
    chk("rw_ch", oADC_CH, 0);
    chk("rw_id", oID, 0);
    chk("rw_data", oDATA, 0);
    chk("rw_err", oERR, 0);
    chk("rw_ovr", oSCAN_OVR, 0);
    begin
      int n;
      n = 0;
      repeat (40) begin
        @(negedge iCLK);
        if (oVALID) n++;
      end
      chk("rw_no_valid", n, 0);
    end
    q.delete();
    rr_ptr = 0;
    eng_delay = 8;
    iREQ = 2'b01;
    deliver("post_rst", 0, 7);
    repeat (3) @(negedge iCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_conv_sched.md
Name: adc_conv_sched

Overview:
- Sequences the 8-channel serial ADC engine (one conversion per frame) and shares it between N_REQ on-demand requesters and a periodic background scanner.
- Round-robin arbitration between sources; one conversion in flight at a time.
- Each result is returned tagged with the requester ID. Scan results land in an 8-entry result bank that the rest of the design reads.
- Sits between the robot control logic and the ADC SPI engine.

Parameters:
N_REQ, 2, number of on-demand requesters (1..7); the scanner is source index N_REQ
DW, 12, ADC result width
SCAN_PERIOD, 50000, iCLK cycles between scan sweep triggers (>=2)
TIMEOUT, 64, iCLK cycles allowed from oADC_START to iADC_DONE before abort

Ports:
iCLK  in  1  system clock
iRST  in  1  synchronous reset, active-high
iREQ  in  N_REQ  per-requester conversion request (level)
iREQ_CH  in  3*N_REQ  channel for requester k at bits [3k+2:3k]
oVALID  out  1  one-cycle result strobe
oID  out  3  source index of the result (N_REQ = scanner)
oDATA  out  DW  conversion result
oERR  out  1  qualifies oVALID: conversion timed out; oDATA=0
iSCAN_EN  in  1  enable periodic scanning
iSCAN_MASK  in  8  channels included in a sweep
oSCAN_OVR  out  1  sticky: trigger arrived while a sweep was pending; cleared by iRST only
iRD_CH  in  3  result bank read address
oRD_DATA  out  DW  bank[iRD_CH], registered, 1-cycle latency
oADC_START  out  1  one-cycle pulse: start a frame
oADC_CH  out  3  channel for the frame; held stable from START until DONE
iADC_DONE  in  1  one-cycle pulse: frame complete, iADC_DATA valid
iADC_DATA  in  DW  engine result

Behaviour:
- Reset (sync, iRST=1) values: FSM=IDLE; oVALID=0; oID=0; oDATA=0; oERR=0; oADC_START=0; oADC_CH=0; oSCAN_OVR=0; rr pointer=0; scan timer=0; scan pending=0; bank all 0; oRD_DATA=0.
- Reset asserted mid-conversion abandons the conversion with no oVALID. A late iADC_DONE is then ignored, because the FSM is in IDLE.
- Request vector: bits 0..N_REQ-1 are iREQ; bit N_REQ is scan-pending.
- Requesters hold iREQ until they see oVALID with their oID. They may drop iREQ in that same cycle.
  - If iREQ is dropped early, a conversion already started still completes and is delivered.
  - iREQ_CH is sampled only at grant.
- FSM:
  - IDLE: if the vector is nonzero, select the first set bit at or after the rr pointer (wrapping). Latch winner ID and channel, then go to START. Otherwise stay in IDLE.
  - START: oADC_START=1 for exactly one cycle; oADC_CH = latched channel. Clear the timeout counter. Go to WAIT.
  - WAIT: on iADC_DONE, capture iADC_DATA and go to DELIVER. Otherwise, when the counter reaches TIMEOUT-1, set the error flag and go to DELIVER. iADC_DONE in the START cycle is ignored.
  - DELIVER: oVALID=1 for one cycle with oID, oDATA, oERR. Set rr pointer = winner+1, wrapping at N_REQ+1. If the winner is the scanner, run the scan bookkeeping below. Go to IDLE.
- Grant latency: request seen in IDLE at cycle t gives oADC_START at t+1. iADC_DONE at cycle d gives oVALID at d+1. Minimum IDLE-to-IDLE period is 4 cycles plus engine time.
- Scan timer:
  - Counts while iSCAN_EN=1 and fires every SCAN_PERIOD cycles.
  - iSCAN_EN=0 clears the timer but does not cancel a pending sweep.
  - On fire with iSCAN_MASK != 0 and no sweep pending: latch the mask, set the channel pointer to the lowest set bit, set scan-pending.
  - On fire with a sweep pending: set oSCAN_OVR and ignore the trigger.
  - On fire with mask 0: no action.
- Scan bookkeeping in DELIVER:
  - If not oERR, write bank[channel] = data. On error the entry is unchanged.
  - Clear the current bit of the latched mask. If none remain, clear scan-pending. Otherwise point to the next set bit.
  - Sweep conversions interleave with requester conversions under round-robin.
- Bank read port: registered. A bank write and a read of the same address in the same cycle return the old value; the new value appears the next cycle.
- oADC_START and oVALID never assert in the same cycle.

Decomposition:
- Shared package adc_pkg holds:
  - constants ADC_NCH=8, ADC_CHW=3, ADC_DW=12
  - FSM state encoding S_IDLE/S_START/S_WAIT/S_DELIVER
  - function rr_pick(vector, pointer) returning the index
- One natural sub-module: adc_scan_timer, containing the period counter, latched mask, next-channel pointer and overrun flag. Interface: fire/pending/channel outputs and an advance input.

Test Plan:
- Single request: iREQ[0]=1, CH=5; engine returns DONE+0xABC 20 cycles after START -> oADC_CH=5, oADC_START one cycle after request, oVALID with oID=0, oDATA=0xABC, oERR=0 one cycle after DONE.
- Contention: iREQ=2'b11 held, scan disabled -> grants alternate 0,1,0,1 over 4 conversions; each requester drops its iREQ on its own oVALID.
- Scan sweep: SCAN_PERIOD=100, mask=8'b1000_0101, no requesters -> conversions on ch0, ch2, ch7 in order; bank[0,2,7] updated; oRD_DATA reflects a write one cycle after the write; pending cleared after ch7.
- Timeout: engine never returns DONE, TIMEOUT=64 -> oVALID with oERR=1, oDATA=0 exactly 64 cycles after START; scan bank entry unchanged; next request is served normally.
- Overrun and interleave: SCAN_PERIOD shorter than one sweep, iREQ[1] held -> oSCAN_OVR rises and stays 1; scan and requester-1 conversions alternate.
- Reset mid-WAIT: iRST=1 for 1 cycle during WAIT, then DONE pulses -> no oVALID; all outputs at reset values; oSCAN_OVR=0.
